// File: rtl/ps2_rx_multi.sv
// ps2_rx_multi: NUM_CH PS/2 receivers that deframe and check each byte, then merge them round-robin onto one channel-tagged valid/ready stream.
// Stop-bit fall -> out_valid 2 cycles later; out_* hold while !out_ready, a full FIFO drops bytes; optional stalled-frame abort via PS2_RX_TIMEOUT_EN.

// fifo: generic FIFO exposing head and next-to-head; a push while full is accepted only alongside a pop.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       dout_nxt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;

  assign full     = (count == CW'(DEPTH));
  assign push_ok  = push && (!full || pop);
  assign dout     = mem[rd_ptr];
  assign dout_nxt = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_rx_multi #(
  parameter int NUM_CH      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 20000,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ps2_clk,
  input  logic [NUM_CH-1:0] ps2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [CHW-1:0]    out_ch,
  output logic [NUM_CH-1:0] frame_err,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] timeout_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  logic [NUM_CH-1:0] clk_s1, clk_s2, clk_s3;
  logic [NUM_CH-1:0] dat_s1, dat_s2;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] push, ferr_now, tout_now, pop, full;
  logic [7:0]        push_dat [NUM_CH];
  logic [7:0]        head     [NUM_CH];
  logic [7:0]        head_nxt [NUM_CH];
  logic [CW-1:0]     count    [NUM_CH];

  logic              hs, load;
  logic              gnt_vld;
  logic [CHW-1:0]    gnt_idx, rr, rr_nxt;
  logic [7:0]        gnt_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= '1;
      clk_s2 <= '1;
      clk_s3 <= '1;
      dat_s1 <= '1;
      dat_s2 <= '1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

`ifndef PS2_RX_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t     state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [8:0] sr_q, sr_d;
    logic       push_c, ferr_c, tout_c;
`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge clk) begin
      if (reset) tcnt_q <= '0;
      else       tcnt_q <= tcnt_d;
    end
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= IDLE;
        bitcnt_q <= '0;
        sr_q     <= '0;
      end else begin
        state_q  <= state_d;
        bitcnt_q <= bitcnt_d;
        sr_q     <= sr_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      sr_d     = sr_q;
      push_c   = 1'b0;
      ferr_c   = 1'b0;
      tout_c   = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tcnt_d   = tcnt_q;
`endif
      case (state_q)
        IDLE: begin
          if (fall[c] && !dat_s2[c]) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
          end
        end
        SHIFT: begin
          // LSB-first: after nine shifts sr holds {parity, D7..D0}
          if (fall[c]) begin
            sr_d     = {dat_s2[c], sr_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd8) state_d = STOP;
          end
        end
        STOP: begin
          if (fall[c]) begin
            state_d = IDLE;
            if (dat_s2[c] && ^sr_q) push_c = 1'b1;
            else                    ferr_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef PS2_RX_TIMEOUT_EN
      if (state_q == IDLE || fall[c]) begin
        tcnt_d = '0;
      end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        tout_c  = 1'b1;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
`endif
    end

    assign push[c]     = push_c;
    assign ferr_now[c] = ferr_c;
    assign tout_now[c] = tout_c;
    assign push_dat[c] = sr_q[7:0];
    // The byte on out_data stays in its FIFO until accepted
    assign pop[c]      = hs && (out_ch == CHW'(c));

    fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[c]),
      .din      (push_dat[c]),
      .pop      (pop[c]),
      .dout     (head[c]),
      .dout_nxt (head_nxt[c]),
      .count    (count[c]),
      .full     (full[c])
    );
  end

  assign hs   = out_valid && out_ready;
  assign load = !out_valid || out_ready;

  // Scan from rr downward-overwriting so the closest non-empty channel wins
  always_comb begin
    int             i;
    logic [CHW-1:0] ii;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_dat = '0;
    rr_nxt  = rr;
    i       = 0;
    ii      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      i = int'(rr) + k;
      if (i >= NUM_CH) i = i - NUM_CH;
      ii = CHW'(i);
      if (pop[ii] ? (count[ii] > CW'(1)) : (count[ii] != '0)) begin
        gnt_vld = 1'b1;
        gnt_idx = ii;
        gnt_dat = pop[ii] ? head_nxt[ii] : head[ii];
        rr_nxt  = (i == NUM_CH - 1) ? '0 : CHW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      rr          <= '0;
      frame_err   <= '0;
      overflow    <= '0;
      timeout_err <= '0;
    end else begin
      frame_err   <= ferr_now;
      overflow    <= push & full & ~pop;
      timeout_err <= tout_now;
      if (load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_data <= gnt_dat;
          out_ch   <= gnt_idx;
          rr       <= rr_nxt;
        end
      end
    end
  end
endmodule
